// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared state encoding, default widths and request-type encoding for mem_access_ctrl
package mem_ctrl_pkg;
    localparam int ADDR_W_DEF = 2;
    localparam int DATA_W_DEF = 8;
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_SETUP   = 3'd1;
    localparam state_t S_STROBE  = 3'd2;
    localparam state_t S_HOLD    = 3'd3;
    localparam state_t S_CAPTURE = 3'd4;
    localparam state_t S_RESP    = 3'd5;
    typedef enum logic {REQ_READ = 1'b0, REQ_WRITE = 1'b1} req_type_e;
endpackage

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences single-byte reads/writes into a latch memory with setup/strobe/hold phases.
// Optional WRITE_VERIFY_EN: writes read back the stored byte and report mismatches via rsp_err.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int STROBE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [DATA_W-1:0] mem_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_store,
    input  logic [DATA_W-1:0] mem_out,
    output logic              busy
);
    localparam int CW = STROBE_CYCLES > 1 ? $clog2(STROBE_CYCLES) : 1;

    state_t        state;
    req_type_e     wr;
    logic [CW-1:0] cnt;
    logic          strobe_done;

    assign req_ready   = state == S_IDLE;
    assign busy        = state != S_IDLE;
    assign mem_store   = state == S_STROBE;
    assign rsp_valid   = state == S_RESP;
    assign strobe_done = cnt == CW'(STROBE_CYCLES - 1);

    // Address/data registers double as the memory drive; they only move on accept, while idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            wr          <= REQ_READ;
            cnt         <= '0;
            mem_address <= '0;
            mem_data    <= '0;
            rsp_data    <= '0;
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    state       <= S_SETUP;
                    wr          <= req_type_e'(req_write);
                    mem_address <= req_addr;
                    mem_data    <= req_data;
                end
                S_SETUP: begin
                    state <= wr == REQ_WRITE ? S_STROBE : S_CAPTURE;
                    cnt   <= '0;
                end
                S_STROBE: begin
                    state <= strobe_done ? S_HOLD : S_STROBE;
                    cnt   <= cnt + 1'b1;
                end
`ifdef WRITE_VERIFY_EN
                S_HOLD: state <= S_CAPTURE;
`else
                S_HOLD: state <= S_IDLE;
`endif
                S_CAPTURE: begin
                    state    <= S_RESP;
                    rsp_data <= mem_out;
                end
                S_RESP: if (rsp_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef WRITE_VERIFY_EN
    always_ff @(posedge clk) begin
        if (!rst_n) rsp_err <= 1'b0;
        else if (state == S_CAPTURE) rsp_err <= wr == REQ_WRITE && mem_out != mem_data;
    end
`else
    assign rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed table plus hand sequences against a behavioural latch-memory model
module tb_mem_access_ctrl;
`ifdef WRITE_VERIFY_EN
    localparam logic VERIFY = 1'b1;
`else
    localparam logic VERIFY = 1'b0;
`endif

    logic       clk = 0, rst_n = 0;
    logic       req_valid = 0, req_write = 0, rsp_ready = 1;
    logic [1:0] req_addr = 0;
    logic [7:0] req_data = 0;
    logic       req_ready, rsp_valid, rsp_err, mem_store, busy;
    logic [7:0] rsp_data, mem_data, mem_out;
    logic [1:0] mem_address;
    logic [7:0] mem [4];
    logic       corrupt = 0;

    logic       req_valid3 = 0, rsp_ready3 = 1;
    logic       req_ready3, rsp_valid3, rsp_err3, mem_store3, busy3;
    logic [7:0] rsp_data3, mem_data3;
    logic [1:0] mem_address3;

    int total = 0, bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_store) mem[mem_address] <= mem_data;
    always_comb mem_out = mem[mem_address] ^ {7'd0, corrupt && mem_address == 2'd2};

    mem_access_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mem_data(mem_data), .mem_address(mem_address), .mem_store(mem_store),
        .mem_out(mem_out), .busy(busy)
    );

    mem_access_ctrl #(.STROBE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_write(1'b1), .req_addr(2'd0), .req_data(8'hFF),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3), .rsp_err(rsp_err3),
        .mem_data(mem_data3), .mem_address(mem_address3), .mem_store(mem_store3),
        .mem_out(mem_data3), .busy(busy3)
    );

    typedef struct {
        logic       w;
        logic [1:0] a;
        logic [7:0] d;
        logic       exp_rsp;
        logic [7:0] exp_data;
    } vec_t;
    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 20 && busy; i++) tick();
        check(name, busy, 0);
    endtask

    task automatic do_txn(input logic w, input logic [1:0] a, input logic [7:0] d,
                          output logic got, output logic [7:0] rd, output logic er);
        got = 0;
        rd  = 0;
        er  = 0;
        for (int i = 0; i < 20 && !req_ready; i++) tick();
        check("ready_wait", req_ready, 1);
        req_valid = 1; req_write = w; req_addr = a; req_data = d; rsp_ready = 1;
        tick();
        req_valid = 0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) begin
                got = 1; rd = rsp_data; er = rsp_err;
                tick();
                break;
            end
            if (!busy) break;
            tick();
        end
        check("txn_end", busy, 0);
    endtask

    initial begin
        logic       got, er, seen;
        logic [7:0] rd;

        vecs[0] = '{1'b1, 2'd0, 8'h11, VERIFY, 8'h11};
        vecs[1] = '{1'b1, 2'd1, 8'h22, VERIFY, 8'h22};
        vecs[2] = '{1'b0, 2'd0, 8'h00, 1'b1,   8'h11};
        vecs[3] = '{1'b0, 2'd1, 8'h00, 1'b1,   8'h22};
        vecs[4] = '{1'b1, 2'd3, 8'hF0, VERIFY, 8'hF0};
        vecs[5] = '{1'b0, 2'd3, 8'h00, 1'b1,   8'hF0};
        vecs[6] = '{1'b1, 2'd1, 8'h3C, VERIFY, 8'h3C};
        vecs[7] = '{1'b0, 2'd1, 8'h00, 1'b1,   8'h3C};

        tick(); tick();
        check("rst_req_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_mem_store", mem_store, 0);
        check("rst_mem_address", mem_address, 0);
        check("rst_mem_data", mem_data, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_err", rsp_err, 0);
        rst_n = 1;
        tick();

        // write addr 2 = A5, cycle-accurate phase checks
        req_valid = 1; req_write = 1; req_addr = 2; req_data = 8'hA5;
        tick();
        req_valid = 0;
        check("w_t1_store", mem_store, 0);
        check("w_t1_addr", mem_address, 2);
        check("w_t1_data", mem_data, 8'hA5);
        check("w_t1_ready", req_ready, 0);
        tick();
        check("w_t2_store", mem_store, 1);
        check("w_t2_addr", mem_address, 2);
        check("w_t2_data", mem_data, 8'hA5);
        tick();
        check("w_t3_store", mem_store, 0);
        check("w_t3_addr", mem_address, 2);
        check("w_t3_data", mem_data, 8'hA5);
        check("w_t3_ready", req_ready, 0);
        tick();
        check("w_t4_ready", req_ready, !VERIFY);
        wait_idle("w_idle");

        for (int i = 0; i < 8; i++) begin
            do_txn(vecs[i].w, vecs[i].a, vecs[i].d, got, rd, er);
            check($sformatf("vec%0d_rsp", i), got, vecs[i].exp_rsp);
            if (vecs[i].exp_rsp) begin
                check($sformatf("vec%0d_data", i), rd, vecs[i].exp_data);
                check($sformatf("vec%0d_err", i), er, 0);
            end
        end

        // read with stalled response, plus a write held by the host meanwhile
        req_valid = 1; req_write = 0; req_addr = 3; rsp_ready = 0;
        tick();
        req_valid = 0;
        tick();
        check("r_t2_valid", rsp_valid, 0);
        tick();
        check("r_t3_valid", rsp_valid, 1);
        req_valid = 1; req_write = 1; req_addr = 0; req_data = 8'h77;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall%0d_valid", i), rsp_valid, 1);
            check($sformatf("stall%0d_data", i), rsp_data, 8'hF0);
            check($sformatf("stall%0d_ready", i), req_ready, 0);
            tick();
        end
        rsp_ready = 1;
        tick();
        check("after_rsp_ready", req_ready, 1);
        check("after_rsp_valid", rsp_valid, 0);
        tick();
        req_valid = 0;
        check("held_accept_busy", busy, 1);
        check("held_accept_data", mem_data, 8'h77);
        wait_idle("held_idle");
        do_txn(1'b0, 2'd0, 8'h00, got, rd, er);
        check("held_read_rsp", got, 1);
        check("held_read_data", rd, 8'h77);

        // reset during STROBE
        req_valid = 1; req_write = 1; req_addr = 0; req_data = 8'h99;
        tick();
        req_valid = 0;
        tick();
        check("abort_pre_store", mem_store, 1);
        rst_n = 0;
        tick();
        check("abort_store", mem_store, 0);
        check("abort_busy", busy, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        rst_n = 1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid || mem_store || busy) seen = 1;
            tick();
        end
        check("abort_quiet", seen, 0);

        // corrupted readback at addr 2
        corrupt = 1;
        do_txn(1'b1, 2'd2, 8'h80, got, rd, er);
        check("corrupt_w_rsp", got, VERIFY);
`ifdef WRITE_VERIFY_EN
        check("corrupt_w_data", rd, 8'h81);
        check("corrupt_w_err", er, 1);
`endif
        do_txn(1'b0, 2'd2, 8'h00, got, rd, er);
        check("corrupt_r_rsp", got, 1);
        check("corrupt_r_data", rd, 8'h81);
        check("corrupt_r_err", er, 0);
        corrupt = 0;

        // three-cycle strobe instance
        req_valid3 = 1;
        tick();
        req_valid3 = 0;
        check("s3_t1_store", mem_store3, 0);
        for (int i = 2; i <= 4; i++) begin
            tick();
            check($sformatf("s3_t%0d_store", i), mem_store3, 1);
        end
        tick();
        check("s3_t5_store", mem_store3, 0);
        check("s3_t5_ready", req_ready3, 0);
        tick();
        check("s3_t6_ready", req_ready3, !VERIFY);
        check("s3_t6_store", mem_store3, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
  ADDR_W, 2, memory address width
  DATA_W, 8, byte width
  STROBE_CYCLES, 1, cycles mem_store is held high per write (>=1)
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  single clock, all logic rising-edge
  rst_n  in  1  reset, synchronous, active-low
  req_valid  in  1  host request valid
  req_ready  out  1  controller can accept a request
  req_write  in  1  1=write, 0=read
  req_addr  in  ADDR_W  target byte
  req_data  in  DATA_W  write data
  rsp_valid  out  1  response valid
  rsp_ready  in  1  host accepts response
  rsp_data  out  DATA_W  read or readback data
  rsp_err  out  1  readback mismatch flag
  mem_data  out  DATA_W  to latch-memory data input
  mem_address  out  ADDR_W  to latch-memory address
  mem_store  out  1  to latch-memory store enable (level)
  mem_out  in  DATA_W  from latch-memory output (combinational)
  busy  out  1  FSM not in IDLE

Function
REQ-003 The FSM SHALL have states IDLE, SETUP, STROBE, HOLD, CAPTURE, RESP.
REQ-004 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on a clock edge where req_valid && req_ready, and req_addr/req_data/req_write SHALL be registered at that edge.
REQ-005 From accept edge T: SETUP during cycle T+1 (mem_address, mem_data driven, mem_store=0).
REQ-006 Write: STROBE for exactly STROBE_CYCLES cycles with mem_store=1, then HOLD one cycle with mem_store=0 and mem_address/mem_data unchanged, then IDLE; with STROBE_CYCLES=1, req_ready SHALL return high at cycle T+4.
REQ-007 mem_store SHALL be 1 only in STROBE; mem_address and mem_data SHALL not change in any cycle where mem_store=1 or in the cycles immediately before or after it.
REQ-008 Read: after SETUP, CAPTURE (cycle T+2) SHALL register mem_out into rsp_data; RESP from T+3 SHALL assert rsp_valid.
REQ-009 In RESP, rsp_valid and rsp_data SHALL stay stable until the edge with rsp_ready=1; the FSM SHALL then go to IDLE, so req_ready returns high the following cycle.
REQ-010 A request presented while busy SHALL not be accepted; the host holds it (no drop, no queueing).
REQ-011 rsp_err SHALL be 0 for every read response.
REQ-012 busy SHALL equal (state != IDLE).

Reset
REQ-013 While rst_n=0 at a clock edge: state=IDLE, mem_store=0, mem_address=0, mem_data=0, rsp_valid=0, rsp_data=0, rsp_err=0, req_ready=1 from the next cycle.
REQ-014 Reset asserted mid-operation, including during STROBE, SHALL abort the transaction, with mem_store low after that edge; any pending response SHALL be discarded.
REQ-015 Memory contents are outside this block's reset; the controller SHALL not issue stores during or after reset without a request.

Configuration
REQ-016 Macro WRITE_VERIFY_EN defined: after HOLD, a write SHALL go through CAPTURE (reads mem_out at the same address) and RESP. It SHALL return rsp_data=readback and rsp_err=(readback != written data).
REQ-017 WRITE_VERIFY_EN undefined: writes SHALL produce no response, CAPTURE/RESP SHALL be reached only by reads, and rsp_err SHALL be tied 0.

Structure
REQ-018 Shared package mem_ctrl_pkg SHALL hold the state enum, default ADDR_W/DATA_W constants, and the request-type encoding.
REQ-019 The block SHALL be a single module with no sub-module: one FSM, one strobe counter sized for STROBE_CYCLES, and the capture registers.

Verification
REQ-020 Reset, then write addr=2 data=0xA5 -> mem_store high exactly cycle T+2, mem_address=2 and mem_data=0xA5 stable T+1..T+3, req_ready high at T+4.
REQ-021 Write 0x3C to addr 1, then read addr 1 with rsp_ready=1 -> rsp_valid at T+3, rsp_data=0x3C, rsp_err=0.
REQ-022 Read addr 3 with rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_data stable for all 5 cycles, req_ready=0; after rsp_ready=1 the next request is accepted.
REQ-023 rst_n=0 during STROBE of a write to addr 0 -> mem_store=0 after that edge, busy=0, rsp_valid=0, no response after release.
REQ-024 WRITE_VERIFY_EN with the model memory forced to corrupt bit 0 at addr 2, write 0x80 -> rsp_data=0x81, rsp_err=1; without the macro, the same write gives no rsp_valid.
REQ-025 STROBE_CYCLES=3, write addr 0 data 0xFF -> mem_store high exactly 3 consecutive cycles, req_ready high at T+6.
